t07_tft_spi_tx: RTL and testbench

T07_TFT_SPI_TX -- requirements
Module: t07_tft_spi_tx

---
 rtl/t07_tft_spi_tx_if.sv | 21 ++
 rtl/t07_tft_spi_tx.sv | 139 +++++++++++++
 tb/tb_t07_tft_spi_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/t07_tft_spi_tx_if.sv
// MMIO-side handshake between the CPU write port and the TFT SPI transmitter.
interface t07_tft_spi_tx_if;
    logic        displayWrite;
    logic [31:0] displayAddr;
    logic [31:0] displayData;
    logic        busyTFT;

    modport master (
        output displayWrite,
        output displayAddr,
        output displayData,
        input  busyTFT
    );

    modport slave (
        input  displayWrite,
        input  displayAddr,
        input  displayData,
        output busyTFT
    );
endinterface

// File: rtl/t07_tft_spi_tx.sv
// MMIO-driven SPI mode-0 transmitter for a TFT panel: 1 command byte or 1/2/4 data bytes.
// Optional macro T07_TFT_LSB_BYTE_FIRST_EN sends multi-byte payloads least-significant byte first.
module t07_tft_spi_tx #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    t07_tft_spi_tx_if.slave  mmio,
    output logic             tft_sclk,
    output logic             tft_mosi,
    output logic             tft_cs_n,
    output logic             tft_dc
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0]  state_q;
    logic        write_q;
    logic [7:0]  div_q;
    logic [5:0]  bits_q;
    logic [31:0] shift_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        cs_n_q;
    logic        dc_q;

    logic        accept;
    logic [31:0] payload;
    logic [5:0]  nbits;
    logic        unused_addr;

    assign unused_addr  = ^{mmio.displayAddr[31:4], mmio.displayAddr[1:0]};
    assign accept       = mmio.displayWrite && !write_q && (state_q == IDLE);
    assign mmio.busyTFT = (state_q != IDLE) || accept;

    assign tft_sclk = sclk_q;
    assign tft_mosi = mosi_q;
    assign tft_cs_n = cs_n_q;
    assign tft_dc   = dc_q;

    // Payload is left-aligned in send order so the shifter always emits bit 31.
    always_comb begin
        payload = 32'd0;
        nbits   = 6'd8;
        case (mmio.displayAddr[3:2])
            2'b10: begin
`ifdef T07_TFT_LSB_BYTE_FIRST_EN
                payload = {mmio.displayData[7:0], mmio.displayData[15:8], 16'd0};
`else
                payload = {mmio.displayData[15:0], 16'd0};
`endif
                nbits   = 6'd16;
            end
            2'b11: begin
`ifdef T07_TFT_LSB_BYTE_FIRST_EN
                payload = {mmio.displayData[7:0], mmio.displayData[15:8],
                           mmio.displayData[23:16], mmio.displayData[31:24]};
`else
                payload = mmio.displayData;
`endif
                nbits   = 6'd32;
            end
            default: begin
                payload = {mmio.displayData[7:0], 24'd0};
                nbits   = 6'd8;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            div_q   <= 8'd0;
            bits_q  <= 6'd0;
            shift_q <= 32'd0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
        end else begin
            write_q <= mmio.displayWrite;
            case (state_q)
                IDLE: begin
                    // Latch at accept so LOAD already presents cs/dc/first bit and
                    // later MMIO bus changes cannot leak into the transfer.
                    if (accept) begin
                        state_q <= LOAD;
                        shift_q <= payload;
                        bits_q  <= nbits;
                        dc_q    <= (mmio.displayAddr[3:2] != 2'b00);
                        cs_n_q  <= 1'b0;
                        mosi_q  <= payload[31];
                        div_q   <= 8'd0;
                    end
                end
                LOAD: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= 8'd0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else if (bits_q == 6'd1) begin
                            state_q <= DONE;
                            sclk_q  <= 1'b0;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                            bits_q  <= 6'd0;
                        end else begin
                            sclk_q  <= 1'b0;
                            shift_q <= {shift_q[30:0], 1'b0};
                            mosi_q  <= shift_q[30];
                            bits_q  <= bits_q - 6'd1;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                DONE: begin
                    if (div_q == DIV_LAST) begin
                        state_q <= IDLE;
                        div_q   <= 8'd0;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t07_tft_spi_tx.sv
// Randomized self-checking bench for t07_tft_spi_tx against a byte-level reference model.
module tb_t07_tft_spi_tx;
    localparam int unsigned DIV = 2;

    logic clk;
    logic rst;
    logic tft_sclk, tft_mosi, tft_cs_n, tft_dc;
    int   n_cmp = 0;
    int   n_bad = 0;

    t07_tft_spi_tx_if bus ();

    t07_tft_spi_tx #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .mmio     (bus),
        .tft_sclk (tft_sclk),
        .tft_mosi (tft_mosi),
        .tft_cs_n (tft_cs_n),
        .tft_dc   (tft_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bytes in send order packed into the low 8*n bits, plus the byte count.
    task automatic model(input logic [1:0] a, input logic [31:0] d, output int n,
                         output logic [31:0] exp);
        logic [7:0] q[$];
        n = (a == 2'd3) ? 4 : (a == 2'd2) ? 2 : 1;
        for (int i = n - 1; i >= 0; i--) q.push_back(d[8*i +: 8]);
`ifdef T07_TFT_LSB_BYTE_FIRST_EN
        q.reverse();
`endif
        exp = 32'd0;
        foreach (q[i]) exp = {exp[23:0], q[i]};
    endtask

    task automatic do_xfer(input logic [1:0] a, input logic [31:0] d, input bit scramble,
                           input int hold, input int pulse_at,
                           output int busy_cyc, output logic [31:0] bits, output int nrise,
                           output int cs_low, output int cs_falls, output logic dc_seen,
                           output int mosi_bad, output bit timeout);
        int c = 0;
        int tail = 0;
        bit started = 0;
        bit ended = 0;
        logic prev_sclk = 1'b0;
        logic prev_cs = 1'b1;
        logic rise_mosi = 1'b0;
        logic [31:0] ad;
        busy_cyc = 0; bits = 32'd0; nrise = 0; cs_low = 0; cs_falls = 0;
        dc_seen = 1'b0; mosi_bad = 0; timeout = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.displayWrite = (c < hold) || (pulse_at > 0 && c == pulse_at);
            if (c == 0) begin
                ad = $urandom;
                ad[3:2] = a;
                bus.displayAddr = ad;
                bus.displayData = d;
            end else if (scramble && c == 1) begin
                bus.displayAddr = 32'd0;
                bus.displayData = 32'd0;
            end
            @(negedge clk);
            if (bus.busyTFT) begin busy_cyc++; started = 1; end
            else if (started) ended = 1;
            if (!tft_cs_n) cs_low++;
            if (prev_cs && !tft_cs_n) cs_falls++;
            if (tft_sclk && !prev_sclk) begin
                nrise++;
                bits = {bits[30:0], tft_mosi};
                rise_mosi = tft_mosi;
                if (nrise == 1) dc_seen = tft_dc;
            end else if (tft_sclk && tft_mosi !== rise_mosi) begin
                mosi_bad++;
            end
            prev_sclk = tft_sclk;
            prev_cs = tft_cs_n;
            if (ended) tail++;
            c++;
            if (ended && c > hold && tail >= 4) break;
            if (c >= 4000) begin timeout = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.displayWrite = 1'b0;
        bus.displayAddr = 32'd0;
        bus.displayData = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (tft_cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", tft_cs_n); end
        n_cmp++; if (tft_sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", tft_sclk); end
        n_cmp++; if (tft_mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", tft_mosi); end
        n_cmp++; if (tft_dc !== 1'b0) begin n_bad++; $display("FAIL reset_dc: got %b want 0", tft_dc); end
        n_cmp++; if (bus.busyTFT !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busyTFT); end
    endtask

    task automatic test_cmd_byte();
        int busy, nr, csl, csf, mb; logic [31:0] b; logic dc; bit to;
        do_xfer(2'b00, 32'h0000_002A, 1'b0, 1, 0, busy, b, nr, csl, csf, dc, mb, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL cmd_timeout: got 1 want 0"); end
        n_cmp++; if (b !== 32'h2A) begin n_bad++; $display("FAIL cmd_bits: got %h want 2a", b); end
        n_cmp++; if (nr != 8) begin n_bad++; $display("FAIL cmd_rises: got %0d want 8", nr); end
        n_cmp++; if (dc !== 1'b0) begin n_bad++; $display("FAIL cmd_dc: got %b want 0", dc); end
        n_cmp++; if (busy != 36) begin n_bad++; $display("FAIL cmd_busy: got %0d want 36", busy); end
        n_cmp++; if (csl != 33 || csf != 1) begin n_bad++; $display("FAIL cmd_cs: got low=%0d falls=%0d want 33/1", csl, csf); end
        n_cmp++; if (mb != 0) begin n_bad++; $display("FAIL cmd_mosi_stable: got %0d changes want 0", mb); end
    endtask

    task automatic test_word();
        int busy, nr, csl, csf, mb; logic [31:0] b, want; logic dc; bit to;
`ifdef T07_TFT_LSB_BYTE_FIRST_EN
        want = 32'h7856_3412;
`else
        want = 32'h1234_5678;
`endif
        do_xfer(2'b11, 32'h1234_5678, 1'b0, 1, 0, busy, b, nr, csl, csf, dc, mb, to);
        n_cmp++; if (b !== want) begin n_bad++; $display("FAIL word_bits: got %h want %h", b, want); end
        n_cmp++; if (nr != 32) begin n_bad++; $display("FAIL word_rises: got %0d want 32", nr); end
        n_cmp++; if (dc !== 1'b1) begin n_bad++; $display("FAIL word_dc: got %b want 1", dc); end
        n_cmp++; if (csf != 1 || csl != 129) begin n_bad++; $display("FAIL word_cs: got low=%0d falls=%0d want 129/1", csl, csf); end
        n_cmp++; if (busy != 132) begin n_bad++; $display("FAIL word_busy: got %0d want 132", busy); end
    endtask

    task automatic test_held_write();
        int busy, nr, csl, csf, mb; logic [31:0] b; logic dc; bit to;
        logic [31:0] d;
        d = $urandom;
        do_xfer(2'b01, d, 1'b0, 200, 0, busy, b, nr, csl, csf, dc, mb, to);
        n_cmp++; if (nr != 8 || csf != 1) begin n_bad++; $display("FAIL held_single: got rises=%0d falls=%0d want 8/1", nr, csf); end
        n_cmp++; if (busy != 36) begin n_bad++; $display("FAIL held_busy: got %0d want 36", busy); end
        n_cmp++; if (b !== {24'd0, d[7:0]}) begin n_bad++; $display("FAIL held_bits: got %h want %h", b, d[7:0]); end
    endtask

    task automatic test_scramble();
        int busy, nr, csl, csf, mb; logic [31:0] b, want; logic dc; bit to;
`ifdef T07_TFT_LSB_BYTE_FIRST_EN
        want = 32'h0000_C3A5;
`else
        want = 32'h0000_A5C3;
`endif
        do_xfer(2'b10, 32'hFFFF_A5C3, 1'b1, 1, 0, busy, b, nr, csl, csf, dc, mb, to);
        n_cmp++; if (b !== want || nr != 16) begin n_bad++; $display("FAIL scramble_bits: got %h/%0d want %h/16", b, nr, want); end
        n_cmp++; if (dc !== 1'b1 || busy != 68) begin n_bad++; $display("FAIL scramble_dc_busy: got %b/%0d want 1/68", dc, busy); end
    endtask

    task automatic test_random();
        int busy, nr, csl, csf, mb, n, pa; logic [31:0] b, exp, d; logic dc; bit to;
        logic [1:0] a;
        for (int k = 0; k < 10; k++) begin
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 30)) : 0;
            model(a, d, n, exp);
            do_xfer(a, d, 1'b0, 1, pa, busy, b, nr, csl, csf, dc, mb, to);
            n_cmp++; if (b !== exp || nr != 8*n) begin n_bad++; $display("FAIL rand_bits[%0d]: got %h/%0d want %h/%0d", k, b, nr, exp, 8*n); end
            n_cmp++; if (busy != int'(2 + 16*DIV*n + DIV)) begin n_bad++; $display("FAIL rand_busy[%0d]: got %0d want %0d", k, busy, 2 + 16*DIV*n + DIV); end
            n_cmp++; if (dc !== (a != 2'd0)) begin n_bad++; $display("FAIL rand_dc[%0d]: got %b want %b", k, dc, a != 2'd0); end
            n_cmp++; if (csl != int'(1 + 16*DIV*n) || csf != 1) begin n_bad++; $display("FAIL rand_cs[%0d]: got low=%0d falls=%0d want %0d/1", k, csl, csf, 1 + 16*DIV*n); end
            n_cmp++; if (mb != 0) begin n_bad++; $display("FAIL rand_mosi_stable[%0d]: got %0d want 0", k, mb); end
        end
    endtask

    task automatic test_reset_abort();
        int busy, nr, csl, csf, mb, rises, extra; logic [31:0] b, d; logic dc; bit to;
        logic prev;
        rises = 0; extra = 0; prev = 1'b0;
        @(posedge clk); #1;
        bus.displayWrite = 1'b1;
        bus.displayAddr = 32'h0000_000C;
        bus.displayData = $urandom;
        for (int c = 0; c < 2000 && rises < 13; c++) begin
            @(negedge clk);
            if (tft_sclk && !prev) rises++;
            prev = tft_sclk;
            if (rises < 13) begin @(posedge clk); #1 bus.displayWrite = 1'b0; end
        end
        n_cmp++; if (rises != 13) begin n_bad++; $display("FAIL abort_reach13: got %0d want 13", rises); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (tft_cs_n !== 1'b1 || tft_sclk !== 1'b0 || bus.busyTFT !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle: got cs_n=%b sclk=%b busy=%b want 1/0/0", tft_cs_n, tft_sclk, bus.busyTFT);
        end
        prev = tft_sclk;
        repeat (40) begin
            @(negedge clk);
            if (tft_sclk && !prev) extra++;
            prev = tft_sclk;
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL abort_no_edges: got %0d want 0", extra); end
        d = $urandom;
        do_xfer(2'b01, d, 1'b0, 1, 0, busy, b, nr, csl, csf, dc, mb, to);
        n_cmp++; if (b !== {24'd0, d[7:0]} || busy != 36) begin n_bad++; $display("FAIL abort_recover: got %h/%0d want %h/36", b, busy, d[7:0]); end
    endtask

    initial begin
        test_reset();
        test_cmd_byte();
        test_word();
        test_held_write();
        test_scramble();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
